// File: rtl/pattern_encoder256_pkg.sv
// Shared constants and encodings for the pattern-decoder link transmitter.
package pattern_encoder256_pkg;
  localparam int WIDTH = 256;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic IDLE_BIT = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_SIG  = 2'd1,
    SEND_PRGM = 2'd2
  } state_e;

  localparam logic MODE_SIG  = 1'b0;
  localparam logic MODE_PRGM = 1'b1;
endpackage

// File: rtl/pattern_encoder256_piso.sv
// Parallel-load / serial-out shift register; the transmit-side twin of the
// decoder's serial-in register. Load has priority over shift.
module piso256
  import pattern_encoder256_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rnot,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] shreg_q;

  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= din;
    end else if (shift) begin
      shreg_q <= {shreg_q[W-2:0], IDLE_BIT};
    end
  end

  assign msb = shreg_q[W-1];
endmodule

// File: rtl/pattern_encoder256.sv
// Serializes 256-bit frames MSB first onto the decoder's signal line or its
// program line (with shift enable), one bit per clock.
module pattern_encoder256
  import pattern_encoder256_pkg::*;
(
  input  logic             clk,
  input  logic             rnot,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_mode,
  output logic             ser_out,
  output logic             prgm_out,
  output logic             prgm_en,
  output logic             busy,
  output logic             frame_done
);
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sig_en_q;
  logic             prgm_en_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             last_bit;
  logic             accept;
  logic             msb;

  // The last-bit cycle doubles as an accept window so frames can abut.
  assign last_bit   = (state_q != IDLE) && (cnt_q == CNT_W'(WIDTH - 1));
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  piso256 #(.W(WIDTH)) u_piso (
    .clk   (clk),
    .rnot  (rnot),
    .load  (accept),
    .shift (state_q != IDLE),
    .din   (load_data),
    .msb   (msb)
  );

  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sig_en_q     <= 1'b0;
      prgm_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_bit;
      if (accept) begin
        cnt_q  <= '0;
        busy_q <= 1'b1;
        if (load_mode == MODE_PRGM) begin
          state_q   <= SEND_PRGM;
          sig_en_q  <= 1'b0;
          prgm_en_q <= 1'b1;
        end else begin
          state_q   <= SEND_SIG;
          sig_en_q  <= 1'b1;
          prgm_en_q <= 1'b0;
        end
      end else if (last_bit) begin
        // Counter holds here; it only wraps through a reload.
        state_q   <= IDLE;
        sig_en_q  <= 1'b0;
        prgm_en_q <= 1'b0;
        busy_q    <= 1'b0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ser_out    = sig_en_q  ? msb : IDLE_BIT;
  assign prgm_out   = prgm_en_q ? msb : IDLE_BIT;
  assign prgm_en    = prgm_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
endmodule
